// File: rtl/add8_err_monitor.sv
`default_nettype none
// ============================================================================
// Module   : add8_err_monitor
// Purpose  : Characterises an approximate adder by comparing its sum against
//            the exact sum and accumulating error statistics for one run.
// Revision : 1.0  initial release
// ============================================================================
module add8_err_monitor #(
    parameter int W         = 8,
    parameter int N_SAMPLES = 65536,
    parameter int CNT_W     = 17,
    parameter int ACC_W     = 32,
    parameter int SQ_W      = 40
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_a,
    input  logic [W-1:0]     in_b,
    input  logic [W:0]       in_o,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] sample_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic [ACC_W-1:0] sum_abs_err,
    output logic [SQ_W-1:0]  sum_sq_err,
    output logic [W:0]       max_err,
    output logic [W-1:0]     max_a,
    output logic [W-1:0]     max_b,
    output logic             sat
);

    localparam int EW  = W + 1;
    localparam int SW  = 2 * W + 2;
    localparam int AXW = ((ACC_W > EW) ? ACC_W : EW) + 1;
    localparam int QXW = ((SQ_W > SW) ? SQ_W : SW) + 1;

    localparam logic [CNT_W-1:0] C_LAST_CNT = CNT_W'(N_SAMPLES - 1);
    localparam logic [AXW-1:0]   C_ACC_MAX  = AXW'({ACC_W{1'b1}});
    localparam logic [QXW-1:0]   C_SQ_MAX   = QXW'({SQ_W{1'b1}});

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   sample_cnt_q, err_cnt_q;
    logic [ACC_W-1:0]   sum_abs_q;
    logic [SQ_W-1:0]    sum_sq_q;
    logic [EW-1:0]      max_err_q;
    logic [W-1:0]       max_a_q, max_b_q;
    logic               sat_q;

    logic               s1_valid_q;
    logic [EW-1:0]      s1_exact_q, s1_o_q;
    logic [W-1:0]       s1_a_q, s1_b_q;

    logic               accept_w;
    logic [EW-1:0]      e_w;
    logic [SW-1:0]      esq_w;
    logic [AXW-1:0]     abs_sum_w;
    logic [QXW-1:0]     sq_sum_w;
    logic               abs_ovf_w, sq_ovf_w;
    logic [ACC_W-1:0]   sum_abs_d;
    logic [SQ_W-1:0]    sum_sq_d;

    // RUN is left on the final accept, so the state alone gates readiness.
    assign in_ready = (state_q == S_RUN);
    assign accept_w = in_valid & in_ready;

    always_comb begin
        e_w       = (s1_exact_q >= s1_o_q) ? (s1_exact_q - s1_o_q) : (s1_o_q - s1_exact_q);
        esq_w     = SW'(e_w) * SW'(e_w);
        abs_sum_w = AXW'(sum_abs_q) + AXW'(e_w);
        sq_sum_w  = QXW'(sum_sq_q) + QXW'(esq_w);
        abs_ovf_w = (abs_sum_w > C_ACC_MAX);
        sq_ovf_w  = (sq_sum_w > C_SQ_MAX);
        sum_abs_d = abs_ovf_w ? {ACC_W{1'b1}} : abs_sum_w[ACC_W-1:0];
        sum_sq_d  = sq_ovf_w ? {SQ_W{1'b1}} : sq_sum_w[SQ_W-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            sample_cnt_q <= '0;
            err_cnt_q    <= '0;
            sum_abs_q    <= '0;
            sum_sq_q     <= '0;
            max_err_q    <= '0;
            max_a_q      <= '0;
            max_b_q      <= '0;
            sat_q        <= 1'b0;
            s1_valid_q   <= 1'b0;
            s1_exact_q   <= '0;
            s1_o_q       <= '0;
            s1_a_q       <= '0;
            s1_b_q       <= '0;
        end else begin
            s1_valid_q <= accept_w;
            if (accept_w) begin
                s1_exact_q <= EW'(in_a) + EW'(in_b);
                s1_o_q     <= in_o;
                s1_a_q     <= in_a;
                s1_b_q     <= in_b;
            end

            // Stage 2: retire the sample held in stage 1 into the statistics.
            if (s1_valid_q) begin
                err_cnt_q <= err_cnt_q + CNT_W'(e_w != '0);
                sum_abs_q <= sum_abs_d;
                sum_sq_q  <= sum_sq_d;
                sat_q     <= sat_q | abs_ovf_w | sq_ovf_w;
                if (e_w > max_err_q) begin
                    max_err_q <= e_w;
                    max_a_q   <= s1_a_q;
                    max_b_q   <= s1_b_q;
                end
            end

            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state_q      <= S_RUN;
                        sample_cnt_q <= '0;
                        err_cnt_q    <= '0;
                        sum_abs_q    <= '0;
                        sum_sq_q     <= '0;
                        max_err_q    <= '0;
                        max_a_q      <= '0;
                        max_b_q      <= '0;
                        sat_q        <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (accept_w) begin
                        sample_cnt_q <= sample_cnt_q + CNT_W'(1);
                        if (sample_cnt_q == C_LAST_CNT) begin
                            state_q <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (!s1_valid_q) begin
                        state_q <= S_DONE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy        = (state_q == S_RUN) | (state_q == S_DRAIN);
    assign done        = (state_q == S_DONE);
    assign sample_cnt  = sample_cnt_q;
    assign err_cnt     = err_cnt_q;
    assign sum_abs_err = sum_abs_q;
    assign sum_sq_err  = sum_sq_q;
    assign max_err     = max_err_q;
    assign max_a       = max_a_q;
    assign max_b       = max_b_q;
    assign sat         = sat_q;

endmodule
`default_nettype wire

// File: tb/tb_add8_err_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_add8_err_monitor
// Purpose  : Directed self-checking bench for add8_err_monitor.
// Revision : 1.0  initial release
// ============================================================================
module tb_add8_err_monitor;

    logic clk;
    logic rst_n;

    // Instance A: default widths, 16-sample runs
    logic        a_start, a_valid, a_ready, a_busy, a_done, a_sat;
    logic [7:0]  a_in_a, a_in_b, a_max_a, a_max_b;
    logic [8:0]  a_in_o, a_max_err;
    logic [16:0] a_scnt, a_ecnt;
    logic [31:0] a_sabs;
    logic [39:0] a_ssq;

    // Instance B: narrow abs accumulator, 3-sample runs
    logic        b_start, b_valid, b_ready, b_busy, b_done, b_sat;
    logic [7:0]  b_in_a, b_in_b, b_max_a, b_max_b;
    logic [8:0]  b_in_o, b_max_err;
    logic [16:0] b_scnt, b_ecnt;
    logic [3:0]  b_sabs;
    logic [39:0] b_ssq;

    int n_chk = 0;
    int n_err = 0;

    add8_err_monitor #(.W(8), .N_SAMPLES(16), .CNT_W(17), .ACC_W(32), .SQ_W(40)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .start(a_start), .in_valid(a_valid), .in_ready(a_ready),
        .in_a(a_in_a), .in_b(a_in_b), .in_o(a_in_o), .busy(a_busy), .done(a_done),
        .sample_cnt(a_scnt), .err_cnt(a_ecnt), .sum_abs_err(a_sabs), .sum_sq_err(a_ssq),
        .max_err(a_max_err), .max_a(a_max_a), .max_b(a_max_b), .sat(a_sat)
    );

    add8_err_monitor #(.W(8), .N_SAMPLES(3), .CNT_W(17), .ACC_W(4), .SQ_W(40)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .start(b_start), .in_valid(b_valid), .in_ready(b_ready),
        .in_a(b_in_a), .in_b(b_in_b), .in_o(b_in_o), .busy(b_busy), .done(b_done),
        .sample_cnt(b_scnt), .err_cnt(b_ecnt), .sum_abs_err(b_sabs), .sum_sq_err(b_ssq),
        .max_err(b_max_err), .max_a(b_max_a), .max_b(b_max_b), .sat(b_sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout: got timeout expected finish");
        $fatal(1, "bench timeout");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // All tasks begin and end just after a falling edge.
    task automatic a_pulse_start();
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
    endtask

    task automatic a_send(input logic [7:0] a, input logic [7:0] b, input logic [8:0] o);
        int guard;
        guard = 0;
        a_in_a = a; a_in_b = b; a_in_o = o; a_valid = 1'b1;
        while (!a_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 20) chk("a_ready_timeout", 64'd0, 64'd1);
        @(negedge clk);
        a_valid = 1'b0;
    endtask

    task automatic b_send(input logic [7:0] a, input logic [7:0] b, input logic [8:0] o);
        int guard;
        guard = 0;
        b_in_a = a; b_in_b = b; b_in_o = o; b_valid = 1'b1;
        while (!b_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 20) chk("b_ready_timeout", 64'd0, 64'd1);
        @(negedge clk);
        b_valid = 1'b0;
    endtask

    // Called right after the final accept edge: done must rise two edges later.
    task automatic a_expect_done();
        chk("drain_done_e0", a_done, 1'b0);
        chk("drain_busy_e0", a_busy, 1'b1);
        chk("drain_ready_e0", a_ready, 1'b0);
        @(negedge clk);
        chk("drain_done_e1", a_done, 1'b0);
        @(negedge clk);
        chk("drain_done_e2", a_done, 1'b1);
        chk("drain_busy_e2", a_busy, 1'b0);
    endtask

    task automatic a_pad_exact(input int n);
        for (int i = 0; i < n; i++) begin
            a_send(8'(i * 3), 8'(i * 7), 9'(i * 10));
        end
    endtask

    initial begin
        logic [7:0]  ra, rb;
        logic [8:0]  rex, ro, re, m_max;
        logic [7:0]  m_ma, m_mb;
        logic [63:0] m_ecnt, m_sabs, m_ssq;

        rst_n = 1'b0;
        a_start = 0; a_valid = 0; a_in_a = 0; a_in_b = 0; a_in_o = 0;
        b_start = 0; b_valid = 0; b_in_a = 0; b_in_b = 0; b_in_o = 0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_ready", a_ready, 1'b0);
        chk("rst_busy", a_busy, 1'b0);
        chk("rst_done", a_done, 1'b0);
        chk("rst_scnt", a_scnt, 17'd0);
        chk("rst_sabs", a_sabs, 32'd0);
        chk("rst_max", a_max_err, 9'd0);
        chk("rst_sat", a_sat, 1'b0);
        rst_n = 1'b1;

        // Idle: valid without start is never accepted
        a_valid = 1'b1; a_in_a = 8'd1; a_in_b = 8'd2; a_in_o = 9'd9;
        repeat (3) @(negedge clk);
        a_valid = 1'b0;
        @(negedge clk);
        chk("idle_scnt", a_scnt, 17'd0);
        chk("idle_ready", a_ready, 1'b0);
        chk("idle_busy", a_busy, 1'b0);

        // Exact adder, 16 back-to-back samples
        a_pulse_start();
        chk("run_ready", a_ready, 1'b1);
        chk("run_busy", a_busy, 1'b1);
        for (int i = 0; i < 16; i++) begin
            a_send(8'(i * 17), 8'(255 - i * 5), 9'(i * 17 + 255 - i * 5));
        end
        a_expect_done();
        chk("exact_scnt", a_scnt, 17'd16);
        chk("exact_ecnt", a_ecnt, 17'd0);
        chk("exact_sabs", a_sabs, 32'd0);
        chk("exact_ssq", a_ssq, 40'd0);
        chk("exact_max", a_max_err, 9'd0);

        // Four directed error samples, padded with exact ones
        a_pulse_start();
        chk("restart_done_drop", a_done, 1'b0);
        chk("restart_scnt_clr", a_scnt, 17'd0);
        a_send(8'd10, 8'd20, 9'd30);
        a_send(8'd10, 8'd20, 9'd25);
        a_send(8'd200, 8'd100, 9'd282);
        a_send(8'd0, 8'd0, 9'd5);
        a_pad_exact(12);
        a_expect_done();
        chk("dir_ecnt", a_ecnt, 17'd3);
        chk("dir_sabs", a_sabs, 32'd28);
        chk("dir_ssq", a_ssq, 40'd374);
        chk("dir_max", a_max_err, 9'd18);
        chk("dir_max_a", a_max_a, 8'd200);
        chk("dir_max_b", a_max_b, 8'd100);

        // Tie on max error: first sample's operands kept
        a_pulse_start();
        a_send(8'd1, 8'd2, 9'd10);
        a_send(8'd50, 8'd60, 9'd103);
        a_pad_exact(14);
        a_expect_done();
        chk("tie_max", a_max_err, 9'd7);
        chk("tie_max_a", a_max_a, 8'd1);
        chk("tie_max_b", a_max_b, 8'd2);
        chk("tie_sabs", a_sabs, 32'd14);
        chk("tie_ssq", a_ssq, 40'd98);

        // Saturation on narrow accumulator
        b_start = 1'b1;
        @(negedge clk);
        b_start = 1'b0;
        for (int i = 0; i < 3; i++) b_send(8'd0, 8'd0, 9'd9);
        repeat (2) @(negedge clk);
        chk("sat_done", b_done, 1'b1);
        chk("sat_sabs", b_sabs, 4'd15);
        chk("sat_flag", b_sat, 1'b1);
        chk("sat_ssq", b_ssq, 40'd243);
        chk("sat_ecnt", b_ecnt, 17'd3);
        b_start = 1'b1;
        @(negedge clk);
        b_start = 1'b0;
        chk("sat_clear", b_sat, 1'b0);
        chk("sat_sabs_clear", b_sabs, 4'd0);

        // Random gaps with an ignored mid-run start
        m_ecnt = 0; m_sabs = 0; m_ssq = 0; m_max = 0; m_ma = 0; m_mb = 0;
        a_pulse_start();
        for (int i = 0; i < 16; i++) begin
            ra  = 8'($urandom_range(0, 255));
            rb  = 8'($urandom_range(0, 255));
            rex = {1'b0, ra} + {1'b0, rb};
            ro  = rex ^ 9'($urandom_range(0, 7));
            re  = (rex >= ro) ? (rex - ro) : (ro - rex);
            if (re != 0) m_ecnt++;
            m_sabs += 64'(re);
            m_ssq  += 64'(re) * 64'(re);
            if (re > m_max) begin
                m_max = re; m_ma = ra; m_mb = rb;
            end
            a_send(ra, rb, ro);
            if (i == 6) begin
                a_pulse_start();
                chk("midstart_busy", a_busy, 1'b1);
                chk("midstart_scnt", a_scnt, 17'd7);
            end
            if (i < 15) repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        a_expect_done();
        chk("rnd_scnt", a_scnt, 17'd16);
        chk("rnd_ecnt", a_ecnt, m_ecnt);
        chk("rnd_sabs", a_sabs, m_sabs);
        chk("rnd_ssq", a_ssq, m_ssq);
        chk("rnd_max", a_max_err, m_max);
        chk("rnd_max_a", a_max_a, m_ma);
        chk("rnd_max_b", a_max_b, m_mb);

        // Asynchronous reset in the middle of a run
        a_pulse_start();
        a_send(8'd5, 8'd5, 9'd1);
        a_send(8'd7, 8'd7, 9'd2);
        a_send(8'd9, 8'd9, 9'd3);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_busy", a_busy, 1'b0);
        chk("arst_ready", a_ready, 1'b0);
        chk("arst_scnt", a_scnt, 17'd0);
        chk("arst_ecnt", a_ecnt, 17'd0);
        chk("arst_sabs", a_sabs, 32'd0);
        chk("arst_max", a_max_err, 9'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("arst_idle_done", a_done, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
